// File: rtl/komut_bellegi_yukleyici.sv
`default_nettype none
// ============================================================================
// Module   : komut_bellegi_yukleyici
// Brief    : Loads a program into instruction RAM over valid/ready, then
//            releases the core and serves instructions combinationally by pc.
// Revision : 1.0
// ============================================================================
module komut_bellegi_yukleyici #(
  parameter int          DEPTH  = 256,
  parameter int          ADDR_W = 8,
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic [31:0]       pc,
  input  logic              hata,
  output logic [31:0]       komut,
  output logic              cpu_reset,
  output logic [1:0]        durum,
  output logic              adres_hata,
  output logic [ADDR_W:0]   yuklu_sayisi
);

  localparam logic [1:0]      c_BOS   = 2'd0;
  localparam logic [1:0]      c_YUKLE = 2'd1;
  localparam logic [1:0]      c_CALIS = 2'd2;
  localparam logic [1:0]      c_DUR   = 2'd3;
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_BIR   = (ADDR_W+1)'(1);

  logic [1:0]        r_durum;
  logic [1:0]        w_sonraki;
  logic [ADDR_W:0]   r_sayi;
  logic [ADDR_W:0]   w_sayi_art;
  logic              r_adres_hata;
  logic              r_cpu_reset;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] w_idx;
  logic              w_aktar;
  logic              w_adres_gecersiz;
  logic              w_cekme_hatasi;

  assign w_idx      = pc[ADDR_W+1:2];
  assign w_sayi_art = r_sayi + c_BIR;
  assign w_aktar    = load_valid & load_ready;

  // Misaligned, beyond the RAM window, or past the loaded program.
  assign w_adres_gecersiz = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0) ||
                            ({1'b0, w_idx} >= r_sayi);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_durum <= c_BOS;
    end else begin
      r_durum <= w_sonraki;
    end
  end

  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      c_BOS, c_YUKLE: begin
        if (w_aktar) begin
          if (load_last || (w_sayi_art == c_DEPTH)) begin
            w_sonraki = c_CALIS;
          end else begin
            w_sonraki = c_YUKLE;
          end
        end
      end
      c_CALIS: begin
        if (w_adres_gecersiz || hata) begin
          w_sonraki = c_DUR;
        end
      end
      default: w_sonraki = c_DUR;
    endcase
  end

  always_comb begin
    load_ready     = (r_durum == c_BOS) || ((r_durum == c_YUKLE) && (r_sayi < c_DEPTH));
    w_cekme_hatasi = (r_durum == c_CALIS) && w_adres_gecersiz;
    komut          = NOP;
    if ((r_durum == c_CALIS) && !w_adres_gecersiz) begin
      komut = r_mem[w_idx];
    end
  end

  // cpu_reset drops only after one full cycle in CALIS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sayi       <= '0;
      r_adres_hata <= 1'b0;
      r_cpu_reset  <= 1'b1;
    end else begin
      if (w_aktar) begin
        r_sayi <= w_sayi_art;
      end
      if (w_cekme_hatasi) begin
        r_adres_hata <= 1'b1;
      end
      r_cpu_reset <= !((r_durum == c_CALIS) && (w_sonraki == c_CALIS));
    end
  end

  always_ff @(posedge clk) begin
    if (w_aktar && !reset) begin
      r_mem[r_sayi[ADDR_W-1:0]] <= load_data;
    end
  end

  assign durum        = r_durum;
  assign yuklu_sayisi = r_sayi;
  assign adres_hata   = r_adres_hata;
  assign cpu_reset    = r_cpu_reset;

endmodule
`default_nettype wire

// File: tb/tb_komut_bellegi_yukleyici.sv
`default_nettype none
// ============================================================================
// Module   : tb_komut_bellegi_yukleyici
// Brief    : Scoreboard bench driving a DEPTH=256 and a DEPTH=4 instance.
// Revision : 1.0
// ============================================================================
module tb_komut_bellegi_yukleyici;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic        k;
    logic [1:0]  durum;
    logic [8:0]  sayi;
    logic        aerr;
    logic        crst;
    logic        rdy;
    logic [31:0] komut;
  } exp_t;

  logic        clk = 1'b0;
  logic        t_reset = 1'b1;
  logic        t_valid = 1'b0;
  logic [31:0] t_data = '0;
  logic        t_last = 1'b0;
  logic [31:0] t_pc = '0;
  logic        t_hata = 1'b0;

  logic [31:0] a_komut, b_komut;
  logic        a_rdy, b_rdy, a_crst, b_crst, a_aerr, b_aerr;
  logic [1:0]  a_durum, b_durum;
  logic [8:0]  a_sayi;
  logic [2:0]  b_sayi;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference model: per instance, a word array plus count and run state.
  int          m_mode [2];
  int          m_cnt  [2];
  int          m_run  [2];
  bit          m_aerr [2];
  logic [31:0] m_mem  [2][256];

  always #5 clk = ~clk;

  komut_bellegi_yukleyici dut (
    .clk(clk), .reset(t_reset), .load_valid(t_valid), .load_ready(a_rdy),
    .load_data(t_data), .load_last(t_last), .pc(t_pc), .hata(t_hata),
    .komut(a_komut), .cpu_reset(a_crst), .durum(a_durum),
    .adres_hata(a_aerr), .yuklu_sayisi(a_sayi)
  );

  komut_bellegi_yukleyici #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .reset(t_reset), .load_valid(t_valid), .load_ready(b_rdy),
    .load_data(t_data), .load_last(t_last), .pc(t_pc), .hata(t_hata),
    .komut(b_komut), .cpu_reset(b_crst), .durum(b_durum),
    .adres_hata(b_aerr), .yuklu_sayisi(b_sayi)
  );

  function automatic int dep(int k);
    return (k == 0) ? 256 : 4;
  endfunction

  function automatic bit m_fault(int k, logic [31:0] p);
    return (p[1:0] != 2'b00) || ({2'b00, p[31:2]} >= 32'(m_cnt[k]));
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    e.k     = (k != 0);
    e.durum = 2'(m_mode[k]);
    e.sayi  = 9'(m_cnt[k]);
    e.aerr  = m_aerr[k];
    e.crst  = !(m_mode[k] == 2 && m_run[k] >= 1);
    e.rdy   = (m_mode[k] == 0) || (m_mode[k] == 1 && m_cnt[k] < dep(k));
    e.komut = NOP;
    if (m_mode[k] == 2 && !m_fault(k, t_pc)) e.komut = m_mem[k][t_pc[31:2]];
    return e;
  endfunction

  task automatic model_update(int k);
    bit rdy;
    rdy = (m_mode[k] == 0) || (m_mode[k] == 1 && m_cnt[k] < dep(k));
    if (t_reset) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_aerr[k] = 0;
    end else if (m_mode[k] <= 1) begin
      if (t_valid && rdy) begin
        m_mem[k][m_cnt[k]] = t_data;
        m_cnt[k]++;
        if (t_last || m_cnt[k] == dep(k)) begin
          m_mode[k] = 2; m_run[k] = 0;
        end else begin
          m_mode[k] = 1;
        end
      end
    end else if (m_mode[k] == 2) begin
      if (m_fault(k, t_pc)) begin
        m_aerr[k] = 1; m_mode[k] = 3;
      end else if (t_hata) begin
        m_mode[k] = 3;
      end else begin
        m_run[k]++;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic l, input logic [31:0] p, input logic h);
    t_reset = r; t_valid = v; t_data = d; t_last = l; t_pc = p; t_hata = h;
    for (int k = 0; k < 2; k++) sb.push_back(model_out(k));
    for (int k = 0; k < 2; k++) model_update(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] p);
    step(1'b0, 1'b0, 32'h0, 1'b0, p, 1'b0);
  endtask

  task automatic rst();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] d, input logic l);
    step(1'b0, 1'b1, d, l, 32'h0, 1'b0);
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, k, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.k) g = '{1'b0, a_durum, a_sayi, a_aerr, a_crst, a_rdy, a_komut};
      else      g = '{1'b1, b_durum, {6'b0, b_sayi}, b_aerr, b_crst, b_rdy, b_komut};
      chk("durum",        e.k, 32'(g.durum), 32'(e.durum));
      chk("yuklu_sayisi", e.k, 32'(g.sayi),  32'(e.sayi));
      chk("adres_hata",   e.k, 32'(g.aerr),  32'(e.aerr));
      chk("cpu_reset",    e.k, 32'(g.crst),  32'(e.crst));
      chk("load_ready",   e.k, 32'(g.rdy),   32'(e.rdy));
      chk("komut",        e.k, g.komut,      e.komut);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, i;
    logic [31:0] p;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_aerr[k] = 0;
    end
    @(posedge clk);
    #1;

    // Three-word program, then fetch across the end of it.
    rst();
    wr(32'h00500093, 1'b0); wr(32'h00A00113, 1'b0); wr(32'h002081B3, 1'b1);
    idle(32'h0); idle(32'h0); idle(32'h4); idle(32'h8); idle(32'hC); idle(32'h0);

    // Single-word program straight from BOS.
    rst(); wr(32'hDEADBEEF, 1'b1); idle(32'h0); idle(32'h0);

    // Six words, no last: DEPTH=4 instance fills and starts.
    rst();
    for (int j = 0; j < 6; j++) wr(32'h1000 + 32'(j), 1'b0);
    idle(32'h10); idle(32'h0);

    // Misaligned fetch.
    rst(); wr(32'hAAAA0001, 1'b0); wr(32'hAAAA0002, 1'b1);
    idle(32'h0); idle(32'h4); idle(32'h2); idle(32'h0);

    // Core error, then loads are ignored.
    rst(); wr(32'hBBBB0001, 1'b0); wr(32'hBBBB0002, 1'b1); idle(32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 1'b1);
    idle(32'h0); wr(32'h12345678, 1'b0); wr(32'h9ABCDEF0, 1'b1); idle(32'h0);

    // Reset mid-load; stale words must not be served.
    rst(); wr(32'hC0000000, 1'b0); wr(32'hC0000001, 1'b0);
    rst(); wr(32'hC1000000, 1'b1); idle(32'h0); idle(32'h0); idle(32'h4); idle(32'h0);

    // Randomized episodes.
    for (int ep = 0; ep < 60; ep++) begin
      rst();
      n = $urandom_range(1, 7);
      i = 0;
      while (i < n) begin
        if ($urandom_range(0, 19) == 0) begin
          rst();
          i = 0;
        end else if ($urandom_range(0, 3) != 0) begin
          wr($urandom, (i == n - 1));
          i++;
        end else begin
          step(1'b0, 1'b0, $urandom, 1'b1, $urandom, 1'b0);
        end
      end
      for (int c = 0; c < 16; c++) begin
        case ($urandom_range(0, 9))
          0:       p = {$urandom_range(0, 8), 2'b00} | 32'($urandom_range(1, 3));
          1:       p = $urandom | 32'h8000_0000;
          default: p = {$urandom_range(0, n), 2'b00};
        endcase
        step(1'b0, ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 1),
             p, ($urandom_range(0, 19) == 0));
      end
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
